alu_nibble_seq: RTL and testbench

//  Execution side of the CPU ALU add/subtract path. It computes 8-bit ADD/ADC/SUB/SBC/CP
//  in two 4-bit passes (low nibble, then high nibble), as the SM83 core does.

---
 rtl/alu_nibble_seq.sv | 155 +++++++++++++++
 tb/tb_alu_nibble_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: 8-bit ADD/ADC/SUB/SBC/CP computed in two nibble passes.
// Start/done handshake; result and flags are registered outputs.
module alu_nibble_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  input  logic       cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_CP  = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [3:0] lo_q, lo_d;
  logic       c4_q, c4_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       z_q, z_d;
  logic       n_q, n_d;
  logic       h_q, h_d;
  logic       c_q, c_d;

  logic       is_sub;
  logic       is_arith;
  logic       ci_lo;
  logic [3:0] bl;
  logic [3:0] bh;
  logic [4:0] lo_sum;
  logic [4:0] hi_sum;
  logic [7:0] full;

  always_comb begin
    is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) ||
               (op_q == OP_CP);
    is_arith = (op_q <= OP_CP);
    // Subtract is a + ~b + ~borrow, so carries invert into borrows
    bl       = is_sub ? ~b_q[3:0] : b_q[3:0];
    bh       = is_sub ? ~b_q[7:4] : b_q[7:4];
    if (is_sub)
      ci_lo = ~((op_q == OP_SBC) & cin_q);
    else
      ci_lo = (op_q == OP_ADC) & cin_q;
    lo_sum = {1'b0, a_q[3:0]} + {1'b0, bl} + {4'b0, ci_lo};
    hi_sum = {1'b0, a_q[7:4]} + {1'b0, bh} + {4'b0, c4_q};
    full   = {hi_sum[3:0], lo_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    lo_d     = lo_q;
    c4_d     = c4_q;
    done_d   = 1'b0;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    h_d      = h_q;
    c_d      = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = opa;
          b_d     = opb;
          cin_d   = cin;
          state_d = S_LO;
        end
      end
      S_LO: begin
        lo_d    = lo_sum[3:0];
        c4_d    = lo_sum[4];
        state_d = S_HI;
      end
      S_HI: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (is_arith) begin
          z_d = (full == 8'd0);
          n_d = is_sub;
          h_d = is_sub ? ~c4_q : c4_q;
          c_d = is_sub ? ~hi_sum[4] : hi_sum[4];
          if (op_q != OP_CP)
            result_d = full;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      cin_q    <= 1'b0;
      lo_q     <= 4'd0;
      c4_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'd0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      h_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      lo_q     <= lo_d;
      c4_q     <= c4_d;
      done_q   <= done_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      h_q      <= h_d;
      c_q      <= c_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_h = h_q;
  assign flag_c = c_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq: directed cases plus random traffic
// against an arithmetic reference model.
module tb_alu_nibble_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] opa = 8'd0;
  logic [7:0] opb = 8'd0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_n;
  logic       flag_h;
  logic       flag_c;

  alu_nibble_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_h (flag_h),
    .flag_c (flag_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] znhc;
    int         edge_no;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_cnt = 0;
  int   next_ok = 0;

  logic [7:0] m_res = 8'd0;
  logic [3:0] m_znhc = 4'd0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, got, exp, edge_cnt - 1);
    end
  endtask

  // Reference: plain integer arithmetic on whole operands
  task automatic model(input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    int ai, bi, k, r;
    logic h, cy, n;
    ai = int'(a);
    bi = int'(b);
    if (o <= 3'd1) begin
      k  = (o == 3'd1) ? int'(c) : 0;
      r  = ai + bi + k;
      h  = ((ai % 16) + (bi % 16) + k) > 15;
      cy = r > 255;
      n  = 1'b0;
    end else begin
      k  = (o == 3'd3) ? int'(c) : 0;
      r  = ai - bi - k;
      h  = (ai % 16) < ((bi % 16) + k);
      cy = ai < (bi + k);
      n  = 1'b1;
    end
    r = r & 255;
    if (o <= 3'd4) begin
      m_znhc = {(r == 0), n, h, cy};
      if (o != 3'd4) m_res = 8'(r);
    end
  endtask

  task automatic issue(input logic s, input logic [2:0] o,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    exp_t e;
    start = s;
    op    = o;
    opa   = a;
    opb   = b;
    cin   = c;
    if (s && edge_cnt >= next_ok) begin
      model(o, a, b, c);
      e.res     = m_res;
      e.znhc    = m_znhc;
      e.edge_no = edge_cnt + 2;
      q.push_back(e);
      next_ok   = edge_cnt + 3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask

  // Start held through the busy cycles with changing operands
  task automatic op3(input logic [2:0] o, input logic [7:0] a,
                     input logic [7:0] b, input logic c);
    issue(1'b1, o, a, b, c);
    issue(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    issue(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_edge", 32'(edge_cnt - 1), 32'(e.edge_no));
          chk("result", 32'(result), 32'(e.res));
          chk("znhc", 32'({flag_z, flag_n, flag_h, flag_c}),
              32'(e.znhc));
        end
      end else if (q.size() != 0 && q[0].edge_no <= edge_cnt - 1) begin
        e = q.pop_front();
        chk("missing_done", 32'(done), 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({busy, done, result, flag_z, flag_n, flag_h,
        flag_c}), 32'd0);
    reset   = 1'b0;
    next_ok = edge_cnt;

    issue(1'b1, 3'd0, 8'd255, 8'd1, 1'b0);
    start = 1'b0;
    chk("busy_after_accept", 32'({busy, done}), 32'b10);
    idle(2);
    op3(3'd1, 8'd15, 8'd0, 1'b1);
    op3(3'd0, 8'h77, 8'h77, 1'b0);
    op3(3'd2, 8'd0, 8'd1, 1'b0);
    op3(3'd3, 8'h10, 8'd0, 1'b1);
    op3(3'd0, 8'h40, 8'h02, 1'b0);
    op3(3'd4, 8'h77, 8'h77, 1'b0);
    idle(1);
    chk("cp_keeps_result", 32'(result), 32'h42);
    op3(3'd6, 8'h01, 8'h01, 1'b0);
    idle(1);

    for (int i = 0; i < 30; i++)
      issue(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    idle(3);

    issue(1'b1, 3'd0, 8'h12, 8'h34, 1'b0);
    issue(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_hi", 32'({busy, done, result, flag_z, flag_n, flag_h,
        flag_c}), 32'd0);
    q.delete();
    m_res   = 8'd0;
    m_znhc  = 4'd0;
    reset   = 1'b0;
    next_ok = edge_cnt;
    idle(4);

    for (int i = 0; i < 400; i++)
      issue(($urandom % 4) != 0, 3'($urandom), 8'($urandom),
            8'($urandom), 1'($urandom));
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
